// File: rtl/pair_avg_pkg.sv
// Shared definitions for the capture-pair averager: FSM states, sample width
// and the {start, mid} packing used by the FIFO writer, the averager and the bench.
package pair_avg_pkg;

  localparam int DATA_W_DEFAULT = 10;

  // Field index within a FIFO word, in units of DATA_W: start high, mid low.
  localparam int START_FIELD = 1;
  localparam int MID_FIELD   = 0;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    ACCUM,
    EMIT
  } state_t;

  function automatic logic [2*DATA_W_DEFAULT-1:0] pack_pair(
    input logic [DATA_W_DEFAULT-1:0] start,
    input logic [DATA_W_DEFAULT-1:0] mid
  );
    logic [2*DATA_W_DEFAULT-1:0] word;
    word = '0;
    word[START_FIELD*DATA_W_DEFAULT +: DATA_W_DEFAULT] = start;
    word[MID_FIELD*DATA_W_DEFAULT +: DATA_W_DEFAULT]   = mid;
    return word;
  endfunction

endpackage

// File: rtl/pair_diff_stats.sv
// Per-pair difference and windowed statistics: running sum, min, max and pair count.
module pair_diff_stats #(
  parameter int DATA_W = 10,
  parameter int LOG2_N = 3,
  localparam int DIFF_W = DATA_W + 1,
  localparam int ACC_W  = DIFF_W + LOG2_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     update,
  input  logic [DATA_W-1:0]        start,
  input  logic [DATA_W-1:0]        mid,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [DIFF_W-1:0] min_val,
  output logic signed [DIFF_W-1:0] max_val,
  output logic                     last
);

  localparam int CNT_W   = LOG2_N + 1;
  localparam int N_PAIRS = 1 << LOG2_N;

  logic signed [DIFF_W-1:0] diff;
  logic [CNT_W-1:0]         cnt;

  // One extra bit on both operands makes the full +/-(2^DATA_W - 1) range exact.
  assign diff = $signed({1'b0, mid}) - $signed({1'b0, start});

  assign last = (cnt == CNT_W'(N_PAIRS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc     <= '0;
      min_val <= '0;
      max_val <= '0;
      cnt     <= '0;
    end else if (update) begin
      acc <= acc + ACC_W'(diff);
      cnt <= cnt + CNT_W'(1);
      // The first pair of a window seeds both extremes.
      if (cnt == '0) begin
        min_val <= diff;
        max_val <= diff;
      end else begin
        if (diff < min_val) min_val <= diff;
        if (diff > max_val) max_val <= diff;
      end
    end
  end

endmodule

// File: rtl/pair_diff_averager.sv
// Pops {start, mid} pairs from the capture FIFO, drops aborted (all-zero) words and
// emits the windowed average, min and max of mid-start over a valid/ready handshake.
module pair_diff_averager
  import pair_avg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int LOG2_N = 3,
  localparam int DIFF_W = DATA_W + 1,
  localparam int ACC_W  = DIFF_W + LOG2_N
) (
  input  logic                rd_clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                flush,
  input  logic                rempty,
  input  logic [2*DATA_W-1:0] rd_data,
  output logic                rd_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIFF_W-1:0]   out_avg,
  output logic [DIFF_W-1:0]   out_min,
  output logic [DIFF_W-1:0]   out_max,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  state_t state, next_state;

  logic [2*DATA_W-1:0]      word_q;
  logic                     flush_pend;
  logic                     set_pend;
  logic                     stats_clear;
  logic                     stats_update;
  logic                     drop_inc;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DIFF_W-1:0] min_val;
  logic signed [DIFF_W-1:0] max_val;
  logic                     last;

  pair_diff_stats #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_stats (
    .clk     (rd_clk),
    .rst     (rst),
    .clear   (stats_clear),
    .update  (stats_update),
    .start   (word_q[START_FIELD*DATA_W +: DATA_W]),
    .mid     (word_q[MID_FIELD*DATA_W +: DATA_W]),
    .acc     (acc),
    .min_val (min_val),
    .max_val (max_val),
    .last    (last)
  );

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state      <= IDLE;
      word_q     <= '0;
      flush_pend <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == LATCH) word_q <= rd_data;
      if (state == ACCUM) flush_pend <= 1'b0;
      else if (set_pend)  flush_pend <= 1'b1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_comb begin
    next_state   = state;
    rd_en        = 1'b0;
    out_valid    = 1'b0;
    stats_clear  = 1'b0;
    stats_update = 1'b0;
    drop_inc     = 1'b0;
    set_pend     = 1'b0;
    case (state)
      IDLE: begin
        if (flush)                  stats_clear = 1'b1;
        else if (enable && !rempty) next_state  = POP;
      end
      POP: begin
        rd_en      = 1'b1;
        set_pend   = flush;
        next_state = LATCH;
      end
      LATCH: begin
        set_pend   = flush;
        next_state = ACCUM;
      end
      ACCUM: begin
        next_state = IDLE;
        // A flush seen while this word was in flight discards it along with the window.
        if (flush_pend || flush) begin
          stats_clear = 1'b1;
        end else if (word_q == '0) begin
          drop_inc = 1'b1;
        end else begin
          stats_update = 1'b1;
          if (last) next_state = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (flush || out_ready) begin
          stats_clear = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign out_avg = DIFF_W'(acc >>> LOG2_N);
  assign out_min = min_val;
  assign out_max = max_val;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_pair_diff_averager.sv
// Directed bench for pair_diff_averager: a FIFO model and a windowed-statistics model
// are checked against the DUT every cycle, plus hand-computed window results.
module tb_pair_diff_averager;
  import pair_avg_pkg::*;

  localparam int DATA_W = DATA_W_DEFAULT;
  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;
  localparam int DIFF_W = DATA_W + 1;

  logic                rd_clk = 1'b0;
  logic                rst;
  logic                enable;
  logic                flush;
  logic                rempty;
  logic [2*DATA_W-1:0] rd_data;
  logic                rd_en;
  logic                out_valid;
  logic                out_ready;
  logic [DIFF_W-1:0]   out_avg;
  logic [DIFF_W-1:0]   out_min;
  logic [DIFF_W-1:0]   out_max;
  logic [15:0]         drop_cnt;
  logic                busy;

  pair_diff_averager #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) dut (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .enable    (enable),
    .flush     (flush),
    .rempty    (rempty),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_min   (out_min),
    .out_max   (out_max),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    int avg;
    int mn;
    int mx;
    int rise;
  } res_t;

  int n_checks;
  int n_fail;
  int cyc;
  int pushed_total;
  int popped_total;
  int exp_drop;
  logic [2*DATA_W-1:0] mem [0:255];
  res_t exp_q[$];
  int   diffs[$];
  int   drop_ev[$];

  assign rempty = (pushed_total == popped_total);

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int sx(input logic [DIFF_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int floorDiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Window model: a popped word lands in the statistics three cycles after its POP cycle.
  task automatic modelConsume(input logic [2*DATA_W-1:0] w, input int at);
    int   s;
    int   mn;
    int   mx;
    res_t r;
    if (w == '0) begin
      drop_ev.push_back(at + 3);
    end else begin
      diffs.push_back(int'(w[DATA_W-1:0]) - int'(w[2*DATA_W-1:DATA_W]));
      if (diffs.size() == N) begin
        s  = 0;
        mn = diffs[0];
        mx = diffs[0];
        foreach (diffs[i]) begin
          s += diffs[i];
          if (diffs[i] < mn) mn = diffs[i];
          if (diffs[i] > mx) mx = diffs[i];
        end
        r.avg  = floorDiv(s, N);
        r.mn   = mn;
        r.mx   = mx;
        r.rise = at + 3;
        exp_q.push_back(r);
        diffs.delete();
      end
    end
  endtask

  task automatic compareLoop();
    int last_pop;
    bit prev_valid;
    logic [2*DATA_W-1:0] w;
    last_pop   = -100;
    prev_valid = 1'b0;
    forever begin
      @(negedge rd_clk);
      cyc++;
      if (rst) begin
        diffs.delete();
        exp_q.delete();
        drop_ev.delete();
        exp_drop   = 0;
        prev_valid = 1'b0;
      end else begin
        if (rd_en) begin
          checkOutput("fifo_nonempty_on_pop", int'(popped_total < pushed_total), 1);
          checkOutput("pop_spacing_ok", int'(cyc - last_pop >= 3), 1);
          checkOutput("no_pop_while_valid", int'(out_valid), 0);
          last_pop = cyc;
          if (popped_total < pushed_total) begin
            w       = mem[popped_total[7:0]];
            rd_data = w;
            popped_total++;
            modelConsume(w, cyc);
          end
        end
        while (drop_ev.size() > 0 && drop_ev[0] <= cyc) begin
          if (exp_drop < 65535) exp_drop++;
          void'(drop_ev.pop_front());
        end
        checkOutput("drop_cnt", int'(drop_cnt), exp_drop);
        if (out_valid && !prev_valid) begin
          checkOutput("pending_results_at_rise", exp_q.size(), 1);
          if (exp_q.size() > 0) checkOutput("valid_latency", cyc, exp_q[0].rise);
        end
        if (out_valid && exp_q.size() > 0) begin
          checkOutput("out_avg", sx(out_avg), exp_q[0].avg);
          checkOutput("out_min", sx(out_min), exp_q[0].mn);
          checkOutput("out_max", sx(out_max), exp_q[0].mx);
          if (out_ready && !flush) void'(exp_q.pop_front());
        end
        if (flush) begin
          diffs.delete();
          exp_q.delete();
        end
        prev_valid = out_valid;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #2;
  endtask

  task automatic pushWord(input logic [2*DATA_W-1:0] w);
    mem[pushed_total[7:0]] = w;
    pushed_total++;
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] start, input logic [DATA_W-1:0] mid);
    pushWord(pack_pair(start, mid));
  endtask

  task automatic waitValid(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge rd_clk);
      i++;
    end while (!out_valid && i < budget);
    checkOutput("wait_valid_in_time", int'(out_valid), 1);
  endtask

  task automatic waitIdle(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge rd_clk);
      i++;
    end while (!(rempty && !busy) && i < budget);
    checkOutput("wait_idle_in_time", int'(rempty && !busy), 1);
  endtask

  task automatic checkWindow(input string tag, input int avg, input int mn, input int mx);
    checkOutput({tag, "_avg"}, sx(out_avg), avg);
    checkOutput({tag, "_min"}, sx(out_min), mn);
    checkOutput({tag, "_max"}, sx(out_max), mx);
  endtask

  initial begin
    int base;
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    pushed_total = 0;
    popped_total = 0;
    exp_drop     = 0;
    rst          = 1'b1;
    enable       = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    rd_data      = '0;
    fork
      compareLoop();
    join_none

    tick(3);
    rst = 1'b0;
    @(negedge rd_clk);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_rd_en", int'(rd_en), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_drop_cnt", int'(drop_cnt), 0);
    checkWindow("reset", 0, 0, 0);

    // Basic window: diffs 0..7.
    tick(1);
    out_ready = 1'b1;
    enable    = 1'b1;
    base      = popped_total;
    for (int k = 0; k < 8; k++) applyStimulus(10'(100), 10'(100 + k));
    waitValid(200);
    checkWindow("basic", 3, 0, 7);
    waitIdle(100);
    checkOutput("basic_pops", popped_total - base, 8);

    // Three aborted words among eight pairs: diffs 10,-10,1,5,-5,2,20,-1.
    tick(1);
    applyStimulus(10'(200), 10'(210));
    pushWord('0);
    applyStimulus(10'(300), 10'(290));
    applyStimulus(10'(50),  10'(51));
    pushWord('0);
    applyStimulus(10'(0),   10'(5));
    applyStimulus(10'(5),   10'(0));
    pushWord('0);
    applyStimulus(10'(400), 10'(402));
    applyStimulus(10'(10),  10'(30));
    applyStimulus(10'(600), 10'(599));
    waitValid(300);
    checkWindow("drop", 2, -10, 20);
    waitIdle(100);
    checkOutput("drop_total", int'(drop_cnt), 3);

    // Backpressure with two windows queued.
    tick(1);
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(10'(500), 10'(500 + 2 * k));
    for (int k = 0; k < 8; k++) applyStimulus(10'(500), 10'(500 - k));
    waitValid(200);
    base = popped_total;
    repeat (20) @(negedge rd_clk);
    checkOutput("bp_no_pops", popped_total - base, 0);
    checkOutput("bp_valid_held", int'(out_valid), 1);
    checkWindow("bp_first", 7, 0, 14);
    tick(1);
    out_ready = 1'b1;
    tick(1);
    waitValid(200);
    checkWindow("bp_second", -4, -7, 0);
    waitIdle(100);

    // Extremes and floor rounding of negative sums.
    tick(1);
    for (int k = 0; k < 8; k++) applyStimulus(10'(1023), 10'(0));
    waitValid(200);
    checkWindow("neg_extreme", -1023, -1023, -1023);
    waitIdle(100);
    tick(1);
    applyStimulus(10'(10), 10'(8));
    for (int k = 0; k < 7; k++) applyStimulus(10'(10), 10'(9));
    waitValid(200);
    checkWindow("neg_floor", -2, -2, -1);
    waitIdle(100);
    tick(1);
    for (int k = 0; k < 8; k++) applyStimulus(10'(0), 10'(1023));
    waitValid(200);
    checkWindow("pos_extreme", 1023, 1023, 1023);
    waitIdle(100);

    // Flush a five-pair partial window, then a clean window of diff 4.
    tick(1);
    for (int k = 0; k < 5; k++) applyStimulus(10'(20), 10'(29));
    waitIdle(100);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(10'(30), 10'(34));
    waitValid(200);
    checkWindow("after_flush", 4, 4, 4);
    waitIdle(100);

    // Reset while a result is held.
    tick(1);
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(10'(40), 10'(45));
    waitValid(200);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge rd_clk);
    checkOutput("emit_reset_valid", int'(out_valid), 0);
    checkOutput("emit_reset_drop_cnt", int'(drop_cnt), 0);
    checkOutput("emit_reset_busy", int'(busy), 0);
    checkWindow("emit_reset", 0, 0, 0);

    // Enable gating: queued words stay put, then drain at the normal pop rate.
    tick(1);
    enable    = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(10'(60), 10'(61));
    base = popped_total;
    repeat (30) @(negedge rd_clk);
    checkOutput("gated_pops", popped_total - base, 0);
    checkOutput("gated_busy", int'(busy), 0);
    tick(1);
    enable = 1'b1;
    repeat (20) @(negedge rd_clk);
    checkOutput("resumed_pops", popped_total - base, 4);
    tick(1);
    for (int k = 0; k < 4; k++) applyStimulus(10'(60), 10'(63));
    waitValid(200);
    checkWindow("gated_window", 2, 1, 3);
    waitIdle(100);

    checkOutput("final_drop_cnt", int'(drop_cnt), 0);
    checkOutput("final_results_pending", exp_q.size(), 0);
    checkOutput("final_partial_pairs", diffs.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pair_diff_averager.md
Name: pair_diff_averager

Overview:
- Downstream consumer of the capture FIFO read port, running in the read clock domain.
- Pops {start_sample, mid_sample} pairs and drops aborted captures (all-zero words written after an over-max analog delay).
- Computes mid minus start per pair and accumulates 2^LOG2_N valid pairs.
- Emits the windowed average, min and max over a valid/ready handshake to the readout logic.

Parameters:
- DATA_W, 10, width of one ADC sample; a FIFO word is 2*DATA_W.
- LOG2_N, 3, log2 of pairs per window (default 8 pairs); legal range 0..6.
- DIFF_W (localparam), DATA_W+1, signed per-pair difference width.
- ACC_W (localparam), DIFF_W+LOG2_N, signed accumulator width; cannot overflow.

Ports:
- rd_clk  in  1  block clock, same as FIFO read clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  allows new FIFO pops; level-sensitive.
- flush  in  1  single-cycle pulse; discards the partial window.
- rempty  in  1  FIFO empty flag.
- rd_data  in  2*DATA_W  FIFO read data, valid the cycle after rd_en; [19:10]=start, [9:0]=mid.
- rd_en  out  1  FIFO pop strobe, one cycle per word.
- out_valid  out  1  window result available.
- out_ready  in  1  consumer accepts result.
- out_avg  out  DIFF_W  signed average difference.
- out_min  out  DIFF_W  signed minimum difference in window.
- out_max  out  DIFF_W  signed maximum difference in window.
- drop_cnt  out  16  count of zero (aborted) pairs since reset; saturates at 16'hFFFF.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: on a rd_clk edge with rst=1, all outputs go to 0 and state goes to IDLE. Accumulator, pair count, min and max are cleared. Reset overrides every other input, including mid-window and mid-handshake.
- FSM states: IDLE, POP, LATCH, ACCUM, EMIT.
- IDLE -> POP when enable=1 and rempty=0.
- POP: rd_en=1 for exactly this cycle; next state LATCH.
- LATCH: register rd_data. rempty is ignored because the word is already popped. Next state ACCUM.
- ACCUM, zero word (rd_data==0): drop_cnt += 1 (saturating), pair count unchanged, -> IDLE.
- ACCUM, nonzero word:
  - diff = zero-extended mid minus zero-extended start, DIFF_W signed.
  - acc += sign-extended diff; min/max update (first pair of a window loads both).
  - cnt += 1; if cnt reaches 2^LOG2_N -> EMIT, else -> IDLE.
- Pop rate: at most one pop every 3 cycles (POP, LATCH, ACCUM) before returning to IDLE.
- EMIT:
  - out_valid=1; out_avg = acc arithmetically shifted right by LOG2_N (floor toward minus infinity).
  - out_avg, out_min and out_max stay stable while out_valid=1 and out_ready=0.
  - No pops occur in EMIT; this is backpressure to the FIFO.
  - When out_valid & out_ready on a clock edge: clear acc, cnt, min and max; out_valid drops the next cycle; -> IDLE.
- Latency: the last window word pops in POP; out_valid rises 3 edges later.
- Enable deasserted mid-sequence: an in-flight POP/LATCH/ACCUM completes; IDLE then waits. Partial window is retained.
- flush:
  - In IDLE or EMIT: clear acc, cnt, min and max; out_valid=0; -> IDLE. A pending result is discarded.
  - In POP or LATCH: sets a pending flag; the word is discarded at ACCUM and the clear is applied there.
  - drop_cnt is never cleared by flush.
- flush and out_ready high together in EMIT: flush wins; the result is not counted as delivered.
- LOG2_N=0: every valid pair emits, and out_avg = out_min = out_max = diff.
- Extremes: start=1023, mid=0 gives diff=-1023; start=0, mid=1023 gives diff=+1023. Both are exact in DIFF_W.

Decomposition:
- Shared package pair_avg_pkg holds:
  - the FSM state enum;
  - the DATA_W default;
  - pair field slice constants (start at high, mid at low).
- The capture/FIFO side and testbench use the same package so the pair packing is identical in both places.
- One sub-module, pair_diff_stats: combinational diff, plus registered acc/min/max/cnt with clear and update controls.
- The FSM and FIFO handshake stay in pair_diff_averager.

Test Plan:
- Basic window: LOG2_N=3, push 8 pairs start=100, mid=100+k for k=0..7, out_ready=1 -> out_avg=3, out_min=0, out_max=7, rd_en pulses=8.
- Drop handling: 3 zero words interleaved among 8 nonzero pairs -> drop_cnt=3, one result, zero words absent from avg/min/max.
- Backpressure: out_ready=0 for 20 cycles with 16 pairs queued -> result held stable, rd_en stays 0 during EMIT, second window follows after accept.
- Negative rounding and extremes: 8 pairs start=1023, mid=0 -> out_avg=-1023. Pairs with diffs summing to -9 over 8 -> out_avg=-2 (floor).
- Flush/reset mid-window: flush after 5 pairs, then 8 pairs diff=4 -> out_avg=4. rst during EMIT -> out_valid=0 next cycle, drop_cnt=0.
- Enable gating: enable=0 with rempty=0 for 30 cycles -> no rd_en. Re-enable -> pops resume at the 3-cycle pop rate.
